// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate clock enable, H/V counters with porch decodes,
// programmable sync polarity, blanked colour outputs and line/frame strobes, all registered.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int CNT_W    = 10,
  parameter int COLOR_W  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clock_100mhz,
  input  logic               reset,
  input  logic               drive_enable,
  input  logic [COLOR_W-1:0] red_color,
  input  logic [COLOR_W-1:0] green_color,
  input  logic [COLOR_W-1:0] blue_color,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] drive_Red,
  output logic [COLOR_W-1:0] drive_Green,
  output logic [COLOR_W-1:0] drive_Blue,
  output logic [CNT_W-1:0]   Hcnt,
  output logic [CNT_W-1:0]   Vcnt,
  output logic               display_active,
  output logic               pixel_tick,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_BEG   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] VA_BEG   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

  logic [DIV_W-1:0] div_p0;
  logic [CNT_W-1:0] h_p0;
  logic [CNT_W-1:0] v_p0;

  logic tick, h_last, v_last, hs_on, vs_on, h_act, v_act, vid_on, line_first;

  // Stage p0: combinational decodes of the live counters
  always_comb begin
    tick       = (div_p0 == DIV_LAST);
    h_last     = (h_p0 == H_LAST);
    v_last     = (v_p0 == V_LAST);
    hs_on      = (h_p0 < HS_END);
    vs_on      = (v_p0 < VS_END);
    h_act      = (h_p0 >= HA_BEG) && (h_p0 < HA_END);
    v_act      = (v_p0 >= VA_BEG) && (v_p0 < VA_END);
    vid_on     = drive_enable && h_act && v_act;
    line_first = (h_p0 == '0) && (div_p0 == '0);
  end

  // Stage p0: divider and raster counters; timing free-runs regardless of drive_enable
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      div_p0 <= '0;
      h_p0   <= '0;
      v_p0   <= '0;
    end else begin
      div_p0 <= tick ? '0 : div_p0 + 1'b1;
      if (tick) begin
        if (h_last) begin
          h_p0 <= '0;
          v_p0 <= v_last ? '0 : v_p0 + 1'b1;
        end else begin
          h_p0 <= h_p0 + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered outputs, one clock behind the counters
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      hsync          <= ~HS_POL;
      vsync          <= ~VS_POL;
      drive_Red      <= '0;
      drive_Green    <= '0;
      drive_Blue     <= '0;
      Hcnt           <= '0;
      Vcnt           <= '0;
      display_active <= 1'b0;
      pixel_tick     <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      hsync          <= hs_on ? HS_POL : ~HS_POL;
      vsync          <= vs_on ? VS_POL : ~VS_POL;
      // blank during both horizontal and vertical retrace
      drive_Red      <= vid_on ? red_color   : '0;
      drive_Green    <= vid_on ? green_color : '0;
      drive_Blue     <= vid_on ? blue_color  : '0;
      Hcnt           <= h_p0;
      Vcnt           <= v_p0;
      display_active <= h_act && v_act;
      pixel_tick     <= tick;
      line_start     <= line_first;
      frame_start    <= line_first && (v_p0 == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: three instances (scaled raster, divide-by-1 with
// positive syncs, default VGA) compared cycle by cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       act;
    logic       tick;
    logic       ls;
    logic       fs;
  } vo_t;

  typedef struct {
    int d;
    int hsy; int hbk; int hac; int hfr;
    int vsy; int vbk; int vac; int vfr;
    bit hpol; bit vpol;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic en;
  logic [3:0] rc, gc, bc;

  logic hs_a, vs_a, act_a, tk_a, ls_a, fs_a;
  logic [3:0] dr_a, dg_a, db_a;
  logic [9:0] hc_a, vc_a;
  logic hs_b, vs_b, act_b, tk_b, ls_b, fs_b;
  logic [3:0] dr_b, dg_b, db_b;
  logic [9:0] hc_b, vc_b;
  logic hs_c, vs_c, act_c, tk_c, ls_c, fs_c;
  logic [3:0] dr_c, dg_c, db_c;
  logic [9:0] hc_c, vc_c;

  vo_t obs_a, obs_b, obs_c;
  assign obs_a = {hs_a, vs_a, dr_a, dg_a, db_a, hc_a, vc_a, act_a, tk_a, ls_a, fs_a};
  assign obs_b = {hs_b, vs_b, dr_b, dg_b, db_b, hc_b, vc_b, act_b, tk_b, ls_b, fs_b};
  assign obs_c = {hs_c, vs_c, dr_c, dg_c, db_c, hc_c, vc_c, act_c, tk_c, ls_c, fs_c};

  cfg_t ca, cb, cc;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(3), .CNT_W(10), .COLOR_W(4),
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (
    .clock_100mhz(clk), .reset(rst_a), .drive_enable(en),
    .red_color(rc), .green_color(gc), .blue_color(bc),
    .hsync(hs_a), .vsync(vs_a), .drive_Red(dr_a), .drive_Green(dg_a), .drive_Blue(db_a),
    .Hcnt(hc_a), .Vcnt(vc_a), .display_active(act_a), .pixel_tick(tk_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .CNT_W(10), .COLOR_W(4),
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .clock_100mhz(clk), .reset(rst_b), .drive_enable(en),
    .red_color(rc), .green_color(gc), .blue_color(bc),
    .hsync(hs_b), .vsync(vs_b), .drive_Red(dr_b), .drive_Green(dg_b), .drive_Blue(db_b),
    .Hcnt(hc_b), .Vcnt(vc_b), .display_active(act_b), .pixel_tick(tk_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen dut_c (
    .clock_100mhz(clk), .reset(rst_c), .drive_enable(en),
    .red_color(rc), .green_color(gc), .blue_color(bc),
    .hsync(hs_c), .vsync(vs_c), .drive_Red(dr_c), .drive_Green(dg_c), .drive_Blue(db_c),
    .Hcnt(hc_c), .Vcnt(vc_c), .display_active(act_c), .pixel_tick(tk_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  // Expected outputs k clocks after reset release (k=0: reset state), from raster arithmetic.
  function automatic vo_t model(cfg_t c, int k, bit e, logic [3:0] r, logic [3:0] g,
                                logic [3:0] b);
    vo_t o;
    int ht, vt, j, p, h, v;
    bit ha, va;
    o = '0;
    if (k == 0) begin
      o.hs = ~c.hpol;
      o.vs = ~c.vpol;
      return o;
    end
    ht = c.hsy + c.hbk + c.hac + c.hfr;
    vt = c.vsy + c.vbk + c.vac + c.vfr;
    j  = k - 1;
    p  = (j / c.d) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    ha = (h >= c.hsy + c.hbk) && (h < c.hsy + c.hbk + c.hac);
    va = (v >= c.vsy + c.vbk) && (v < c.vsy + c.vbk + c.vac);
    o.hs   = (h < c.hsy) ? c.hpol : ~c.hpol;
    o.vs   = (v < c.vsy) ? c.vpol : ~c.vpol;
    o.hc   = 10'(h);
    o.vc   = 10'(v);
    o.act  = ha && va;
    o.tick = ((j % c.d) == c.d - 1);
    o.ls   = (h == 0) && ((j % c.d) == 0);
    o.fs   = o.ls && (v == 0);
    if (e && ha && va) begin
      o.r = r; o.g = g; o.b = b;
    end
    return o;
  endfunction

  function automatic int line_clks(cfg_t c);
    return (c.hsy + c.hbk + c.hac + c.hfr) * c.d;
  endfunction

  function automatic int frame_clks(cfg_t c);
    return line_clks(c) * (c.vsy + c.vbk + c.vac + c.vfr);
  endfunction

  task automatic rand_inputs();
    en = 1'($urandom_range(0, 1));
    rc = 4'($urandom);
    gc = 4'($urandom);
    bc = 4'($urandom);
  endtask

  task automatic pulse_reset_a();
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    vo_t exp;
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      exp = model(ca, 0, en, rc, gc, bc);
      @(negedge clk);
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL reset_hold got=%h want=%h", obs_a, exp);
      end
    end
    rst_a = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      rand_inputs();
      exp = model(ca, k, en, rc, gc, bc);
      @(negedge clk);
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL after_reset k=%0d got=%h want=%h", k, obs_a, exp);
      end
      if (k == 1) begin
        total++;
        if ({obs_a.ls, obs_a.fs, obs_a.hs, obs_a.vs, obs_a.hc, obs_a.vc} !== {4'b1100, 20'd0}) begin
          bad++;
          $display("FAIL first_cycle got ls=%b fs=%b hs=%b vs=%b hc=%0d vc=%0d want 1 1 0 0 0 0",
                   obs_a.ls, obs_a.fs, obs_a.hs, obs_a.vs, obs_a.hc, obs_a.vc);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    vo_t exp;
    int fr, vt, last_fs, ls_cnt;
    fr = frame_clks(ca);
    vt = ca.vsy + ca.vbk + ca.vac + ca.vfr;
    pulse_reset_a();
    last_fs = -1;
    ls_cnt  = 0;
    for (int k = 1; k <= 2 * fr + 30; k++) begin
      rand_inputs();
      exp = model(ca, k, en, rc, gc, bc);
      @(negedge clk);
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL rand_model k=%0d got=%h want=%h", k, obs_a, exp);
      end
      total++;
      if (obs_a.vc >= 10'(vt)) begin
        bad++;
        $display("FAIL vcnt_range k=%0d got=%0d want <%0d", k, obs_a.vc, vt);
      end
      if (obs_a.fs) begin
        if (last_fs >= 0) begin
          total++;
          if (k - last_fs != fr) begin
            bad++;
            $display("FAIL frame_period got=%0d want=%0d", k - last_fs, fr);
          end
          total++;
          if (ls_cnt != vt) begin
            bad++;
            $display("FAIL lines_per_frame got=%0d want=%0d", ls_cnt, vt);
          end
        end
        last_fs = k;
        ls_cnt  = 0;
      end
      if (obs_a.ls) ls_cnt++;
    end
  endtask

  task automatic test_colour_gating();
    vo_t exp;
    int fr, lit, dark;
    fr = frame_clks(ca);
    pulse_reset_a();
    lit = 0;
    en = 1'b1; rc = 4'hF; gc = 4'hF; bc = 4'hF;
    for (int k = 1; k <= fr; k++) begin
      exp = model(ca, k, en, rc, gc, bc);
      @(negedge clk);
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL gate_on k=%0d got=%h want=%h", k, obs_a, exp);
      end
      if ({obs_a.r, obs_a.g, obs_a.b} == 12'hFFF) lit++;
    end
    total++;
    if (lit != ca.hac * ca.vac * ca.d) begin
      bad++;
      $display("FAIL lit_count got=%0d want=%0d", lit, ca.hac * ca.vac * ca.d);
    end
    en = 1'b0;
    dark = 0;
    for (int k = fr + 1; k <= 2 * fr; k++) begin
      rc = 4'($urandom); gc = 4'($urandom); bc = 4'($urandom);
      @(negedge clk);
      if ({obs_a.r, obs_a.g, obs_a.b} != 12'h000) dark++;
    end
    total++;
    if (dark != 0) begin
      bad++;
      $display("FAIL gate_off_nonzero got=%0d want=0", dark);
    end
  endtask

  task automatic test_mid_reset();
    vo_t exp;
    int fr, fs_cnt;
    bit found;
    fr = frame_clks(ca);
    pulse_reset_a();
    found = 1'b0;
    for (int i = 0; i < 2 * fr; i++) begin
      rand_inputs();
      @(negedge clk);
      if (obs_a.hc == 10'd10 && obs_a.vc == 10'd6) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_reset_reach got=timeout want=hc10_vc6");
    end
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      exp = model(ca, 0, en, rc, gc, bc);
      @(negedge clk);
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL mid_reset_hold got=%h want=%h", obs_a, exp);
      end
    end
    rst_a = 1'b0;
    fs_cnt = 0;
    for (int k = 1; k <= fr; k++) begin
      rand_inputs();
      exp = model(ca, k, en, rc, gc, bc);
      @(negedge clk);
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL mid_reset_after k=%0d got=%h want=%h", k, obs_a, exp);
      end
      if (obs_a.fs) fs_cnt++;
    end
    total++;
    if (fs_cnt != 1) begin
      bad++;
      $display("FAIL mid_reset_fs_count got=%0d want=1", fs_cnt);
    end
  endtask

  task automatic test_div1_pos_sync();
    vo_t exp;
    int last_ls, hs_cnt, lc, low_tick;
    lc = line_clks(cb);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    last_ls = -1; hs_cnt = 0; low_tick = 0;
    for (int k = 1; k <= 2 * frame_clks(cb) + 5; k++) begin
      rand_inputs();
      exp = model(cb, k, en, rc, gc, bc);
      @(negedge clk);
      total++;
      if (obs_b !== exp) begin
        bad++;
        $display("FAIL div1_model k=%0d got=%h want=%h", k, obs_b, exp);
      end
      if (!obs_b.tick) low_tick++;
      if (obs_b.ls) begin
        if (last_ls >= 0) begin
          total++;
          if (k - last_ls != lc || hs_cnt != cb.hsy) begin
            bad++;
            $display("FAIL div1_line got period=%0d hs=%0d want period=%0d hs=%0d",
                     k - last_ls, hs_cnt, lc, cb.hsy);
          end
        end
        last_ls = k;
        hs_cnt  = 0;
      end
      if (obs_b.hs) hs_cnt++;
    end
    total++;
    if (low_tick != 0) begin
      bad++;
      $display("FAIL div1_tick_low got=%0d want=0", low_tick);
    end
  endtask

  task automatic test_default_params();
    vo_t exp;
    int last_ls, hs_low, vs_low, lit, lc;
    lc = line_clks(cc);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    last_ls = -1; hs_low = 0; vs_low = 0; lit = 0;
    en = 1'b1; rc = 4'hF; gc = 4'hF; bc = 4'hF;
    for (int k = 1; k <= 3 * lc + 5; k++) begin
      exp = model(cc, k, en, rc, gc, bc);
      @(negedge clk);
      total++;
      if (obs_c !== exp) begin
        bad++;
        $display("FAIL default_model k=%0d got=%h want=%h", k, obs_c, exp);
      end
      if ({obs_c.r, obs_c.g, obs_c.b} != 12'h000) lit++;
      if (!obs_c.vs) vs_low++;
      if (obs_c.ls) begin
        if (last_ls >= 0) begin
          total++;
          if (k - last_ls != 3200 || hs_low != 384) begin
            bad++;
            $display("FAIL default_line got period=%0d hs_low=%0d want period=3200 hs_low=384",
                     k - last_ls, hs_low);
          end
        end
        last_ls = k;
        hs_low  = 0;
      end
      if (!obs_c.hs) hs_low++;
    end
    total++;
    if (vs_low != 6400) begin
      bad++;
      $display("FAIL default_vsync_low got=%0d want=6400", vs_low);
    end
    total++;
    if (lit != 0) begin
      bad++;
      $display("FAIL default_vblank_colour got=%0d want=0", lit);
    end
  endtask

  initial begin
    ca = '{3, 4, 3, 8, 2, 2, 2, 5, 1, 1'b0, 1'b0};
    cb = '{1, 4, 3, 8, 2, 2, 2, 5, 1, 1'b1, 1'b1};
    cc = '{4, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0};
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en = 1'b0; rc = '0; gc = '0; bc = '0;
    test_reset();
    test_random_frames();
    test_colour_gating();
    test_mid_reset();
    test_div1_pos_sync();
    test_default_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
